// File: rtl/clock_monitor_pkg.sv
// Shared types and constants for the clock frequency monitor.
package clock_monitor_pkg;

  localparam int COUNT_W = 32;
  localparam logic [COUNT_W-1:0] COUNT_SAT = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    REPORT
  } state_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_SAT) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/clock_monitor_if.sv
// Monitored clock, enable and measurement result bundle; master drives mon_clk/enable, slave reports.
interface clock_monitor_if;
  import clock_monitor_pkg::*;

  logic               mon_clk;
  logic               enable;
  logic               measure_valid;
  logic [COUNT_W-1:0] measure_count;
  logic               clock_ok;
  logic               clock_lost;

  modport master (
    output mon_clk, enable,
    input  measure_valid, measure_count, clock_ok, clock_lost
  );

  modport slave (
    input  mon_clk, enable,
    output measure_valid, measure_count, clock_ok, clock_lost
  );

endinterface

// File: rtl/clock_monitor_sync.sv
// Two-flop synchronizer plus history flop; rise pulses one cycle per synchronized rising edge.
// Latency 2-3 clk from the asynchronous edge; no backpressure.
module clock_monitor_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic sync1, sync2, hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

endmodule

// File: rtl/clock_monitor.sv
// Counts mon_clk rising edges over a gate of gate_cycles clk cycles and reports count/ok/lost.
// Result every gate_cycles+2 cycles while enabled; no backpressure, dropping enable discards the window.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int input_frequency = 100_000_000,
  parameter int gate_cycles     = 100_000,
  parameter int expected_count  = int'(64'(gate_cycles) * 64'd16_000_000 / 64'(input_frequency)),
  parameter int tolerance       = 16
) (
  input logic            clk,
  input logic            reset_n,
  clock_monitor_if.slave mon
);

  localparam int TW = $clog2(gate_cycles + 1);
  localparam logic [TW-1:0] GATE_LAST = TW'(gate_cycles - 1);
  localparam logic signed [COUNT_W:0] EXP_S = $signed((COUNT_W+1)'(expected_count));
  localparam logic signed [COUNT_W:0] TOL_S = $signed((COUNT_W+1)'(tolerance));

  logic [1:0]         rst_sync;
  logic               rst_n_int;
  logic               mon_rise;
  state_t             state, state_nxt;
  logic [TW-1:0]      gate_timer;
  logic [COUNT_W-1:0] edge_count;
  logic signed [COUNT_W:0] diff, mag;
  logic               in_tol;
  logic               measure_valid, clock_ok, clock_lost;
  logic [COUNT_W-1:0] measure_count;

  // Assertion is immediate; release reaches the logic two clk edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  clock_monitor_sync u_sync (
    .clk      (clk),
    .reset_n  (rst_n_int),
    .async_in (mon.mon_clk),
    .rise     (mon_rise)
  );

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mon.enable) state_nxt = ARM;
      ARM:     state_nxt = mon.enable ? GATE : IDLE;
      GATE: begin
        if (!mon.enable)               state_nxt = IDLE;
        else if (gate_timer == GATE_LAST) state_nxt = REPORT;
      end
      REPORT:  state_nxt = mon.enable ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      gate_timer <= '0;
      edge_count <= '0;
    end else begin
      case (state)
        ARM: begin
          gate_timer <= '0;
          edge_count <= '0;
        end
        GATE: begin
          gate_timer <= gate_timer + TW'(1);
          if (mon_rise) edge_count <= sat_inc(edge_count);
        end
        default: ;
      endcase
    end
  end

  // Unsigned count widened by one bit so the difference never overflows.
  always_comb begin
    diff   = $signed({1'b0, edge_count}) - EXP_S;
    mag    = diff[COUNT_W] ? -diff : diff;
    in_tol = (mag <= TOL_S);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      measure_valid <= 1'b0;
      measure_count <= '0;
      clock_ok      <= 1'b0;
      clock_lost    <= 1'b0;
    end else begin
      measure_valid <= (state == REPORT);
      if (state == REPORT) begin
        measure_count <= edge_count;
        clock_ok      <= in_tol;
        clock_lost    <= (edge_count == '0);
      end
    end
  end

  assign mon.measure_valid = measure_valid;
  assign mon.measure_count = measure_count;
  assign mon.clock_ok      = clock_ok;
  assign mon.clock_lost    = clock_lost;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: two instances (1000-cycle and 2-cycle gates) against a window-level model.
`timescale 1ps/1ps
module tb_clock_monitor;
  import clock_monitor_pkg::*;

  localparam int N_A = 1000, EXP_A = 160, TOL_A = 2;
  localparam int N_B = 2,    EXP_B = 1,   TOL_B = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic mon_clk = 1'b0;
  int   mon_half = 31250;
  bit   mon_on = 1'b1;
  int   mon_edges = 0;

  int tests = 0;
  int failed = 0;

  clock_monitor_if if_a ();
  clock_monitor_if if_b ();
  assign if_a.mon_clk = mon_clk;
  assign if_b.mon_clk = mon_clk;

  clock_monitor #(.input_frequency(100_000_000), .gate_cycles(N_A),
                  .expected_count(EXP_A), .tolerance(TOL_A))
    dut_a (.clk(clk), .reset_n(reset_n), .mon(if_a));

  clock_monitor #(.input_frequency(100_000_000), .gate_cycles(N_B),
                  .expected_count(EXP_B), .tolerance(TOL_B))
    dut_b (.clk(clk), .reset_n(reset_n), .mon(if_b));

  always #5000 clk = ~clk;

  // mon_clk edges sit on a 1250 ps grid offset by 1000 ps, never on a clk edge.
  initial begin
    #1000;
    forever begin
      #(mon_half);
      mon_clk = mon_on ? ~mon_clk : 1'b0;
    end
  end

  always @(posedge mon_clk) mon_edges++;

  task automatic chk(input string name, input longint act, input longint lo, input longint hi);
    tests++;
    if (act < lo || act > hi) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  function automatic void get_out(input int i, output bit v, output longint c,
                                  output bit o, output bit l);
    if (i == 0) begin
      v = if_a.measure_valid; c = longint'(if_a.measure_count);
      o = if_a.clock_ok;      l = if_a.clock_lost;
    end else begin
      v = if_b.measure_valid; c = longint'(if_b.measure_count);
      o = if_b.clock_ok;      l = if_b.clock_lost;
    end
  endfunction

  // Window model: a window starts on the edge enable is seen high while idle,
  // survives only if enable stays high for the next N+1 edges, and reports on edge N+2.
  int  cyc = 0;
  int  chg_cnt = 0;
  int  last_chg_cyc = -100;
  bit  run[2];
  int  start[2];
  int  w0[2];
  int  w_chg[2];
  bit  w_clean[2];
  int  win[2];
  bit  win_ok[2];
  bit  exp_vld[2];

  task automatic note_change();
    chg_cnt++;
    last_chg_cyc = cyc;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int pos;
      int n;
      bit en;
      n  = (i == 0) ? N_A : N_B;
      en = (i == 0) ? if_a.enable : if_b.enable;
      exp_vld[i] = 1'b0;
      if (!reset_n) begin
        run[i] = 1'b0;
      end else if (run[i]) begin
        pos = cyc - start[i];
        if (pos == 1) begin
          w0[i] = mon_edges;
          w_chg[i] = chg_cnt;
          w_clean[i] = (cyc - last_chg_cyc) > 6;
        end
        if (pos == n + 1) begin
          win[i] = mon_edges - w0[i];
          win_ok[i] = w_clean[i] && (chg_cnt == w_chg[i]);
        end
        if (pos <= n + 1 && !en) begin
          run[i] = 1'b0;
        end else if (pos == n + 2) begin
          exp_vld[i] = 1'b1;
          if (en) start[i] = cyc;
          else    run[i] = 1'b0;
        end
      end else if (en) begin
        run[i] = 1'b1;
        start[i] = cyc;
      end
    end
    cyc++;
  end

  longint held_c[2];
  bit     held_o[2];
  bit     held_l[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit v, o, l;
      longint c, e, t, d;
      string p;
      p = (i == 0) ? "a" : "b";
      e = (i == 0) ? EXP_A : EXP_B;
      t = (i == 0) ? TOL_A : TOL_B;
      get_out(i, v, c, o, l);
      if (!reset_n) begin
        chk({p, "_reset_outputs_zero"}, c + longint'(v) + longint'(o) + longint'(l), 0, 0);
        held_c[i] = 0; held_o[i] = 0; held_l[i] = 0;
      end else begin
        chk({p, "_valid_timing"}, longint'(v), longint'(exp_vld[i]), longint'(exp_vld[i]));
        if (v) begin
          if (win_ok[i]) chk({p, "_count_vs_model"}, c, win[i] - 1, win[i] + 1);
          d = (c > e) ? c - e : e - c;
          chk({p, "_ok_rule"}, longint'(o), longint'(d <= t), longint'(d <= t));
          chk({p, "_lost_rule"}, longint'(l), longint'(c == 0), longint'(c == 0));
          held_c[i] = c; held_o[i] = o; held_l[i] = l;
        end else begin
          chk({p, "_count_hold"}, c, held_c[i], held_c[i]);
          chk({p, "_flags_hold"}, longint'({o, l}), longint'({held_o[i], held_l[i]}),
              longint'({held_o[i], held_l[i]}));
        end
      end
    end
    chk("b_no_x", longint'($isunknown({if_b.measure_valid, if_b.measure_count,
                                       if_b.clock_ok, if_b.clock_lost})), 0, 0);
  end

  task automatic wait_pulse(input int i, input int budget, output int n);
    bit v, o, l;
    longint c;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      get_out(i, v, c, o, l);
    end while (!v && n < budget);
    chk($sformatf("pulse_seen_inst%0d", i), longint'(v), 1, 1);
  endtask

  initial begin
    int d;
    bit v, o, l;
    longint c;
    if_a.enable = 1'b0;
    if_b.enable = 1'b0;
    #100 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    get_out(0, v, c, o, l);
    chk("reset_valid", longint'(v), 0, 0);
    chk("reset_count", c, 0, 0);
    chk("reset_ok", longint'(o), 0, 0);
    chk("reset_lost", longint'(l), 0, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 16 MHz: enable seen at the next posedge, pulse N+2 edges later -> N+3 negedges.
    if_a.enable = 1'b1;
    wait_pulse(0, 1200, d);
    chk("first_latency", d, N_A + 3, N_A + 3);
    get_out(0, v, c, o, l);
    chk("cnt_16mhz", c, 159, 161);
    chk("ok_16mhz", longint'(o), 1, 1);
    chk("lost_16mhz", longint'(l), 0, 0);
    wait_pulse(0, 1200, d);
    chk("period_16mhz", d, 1002, 1002);
    get_out(0, v, c, o, l);
    chk("cnt_16mhz_2", c, 159, 161);

    // Stopped clock
    mon_on = 1'b0; note_change();
    wait_pulse(0, 1200, d);
    wait_pulse(0, 1200, d);
    get_out(0, v, c, o, l);
    chk("cnt_stopped", c, 0, 0);
    chk("lost_stopped", longint'(l), 1, 1);
    chk("ok_stopped", longint'(o), 0, 0);

    // 20 MHz
    mon_half = 25000; mon_on = 1'b1; note_change();
    wait_pulse(0, 1200, d);
    wait_pulse(0, 1200, d);
    get_out(0, v, c, o, l);
    chk("cnt_20mhz", c, 199, 201);
    chk("ok_20mhz", longint'(o), 0, 0);
    chk("lost_20mhz", longint'(l), 0, 0);

    // Abort mid-gate, re-enable 10 cycles later
    repeat (501) @(negedge clk);
    if_a.enable = 1'b0;
    repeat (10) @(negedge clk);
    get_out(0, v, c, o, l);
    chk("abort_hold_cnt", c, 199, 201);
    if_a.enable = 1'b1;
    wait_pulse(0, 1200, d);
    chk("reentry_latency", d, N_A + 3, N_A + 3);

    // Reset mid-gate
    repeat (300) @(negedge clk);
    #2000 reset_n = 1'b0;
    #1;
    get_out(0, v, c, o, l);
    chk("midreset_count", c, 0, 0);
    chk("midreset_flags", longint'({v, o, l}), 0, 0);
    @(negedge clk);
    if_a.enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    if_a.enable = 1'b1;
    wait_pulse(0, 1200, d);
    chk("post_reset_latency", d, N_A + 3, N_A + 3);
    get_out(0, v, c, o, l);
    chk("post_reset_cnt", c, 199, 201);
    chk("post_reset_lost", longint'(l), 0, 0);

    // Tiny gate, mon_clk = clk/4
    if_a.enable = 1'b0;
    mon_half = 20000; note_change();
    repeat (10) @(negedge clk);
    if_b.enable = 1'b1;
    wait_pulse(1, 20, d);
    chk("tiny_latency", d, N_B + 3, N_B + 3);
    for (int k = 0; k < 6; k++) begin
      wait_pulse(1, 20, d);
      chk("tiny_period", d, 4, 4);
      get_out(1, v, c, o, l);
      chk("tiny_cnt", c, 0, 1);
    end
    if_b.enable = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
# clock_monitor

Frequency monitor for divided clocks produced by the sigma-delta clock divider. It samples a monitored clock (e.g. the 16 MHz divider output) as a plain signal in the `clk` domain and counts its rising edges over a fixed gate window of `clk` cycles. After each window it reports the count, an in-tolerance flag and a loss-of-clock flag. It sits directly downstream of the divider and feeds the health/status logic.

## Interface
- `input_frequency`, default 100_000_000: `clk` frequency in Hz; documentation and default derivation only.
- `gate_cycles`, default 100_000: gate window length in `clk` cycles (1 ms at default). Legal range ≥ 2.
- `expected_count`, default 16_000: nominal edge count per window.
- `tolerance`, default 16: maximum allowed |count − expected_count| for `clock_ok`.
- `reset_n`  input  1  asynchronous, active-low reset.
- `clk`  input  1  sampling/system clock; the only clock in the block.
- `mon_clk`  input  1  monitored clock, treated as asynchronous data. Never used as a clock.
- `enable`  input  1  level; measurements run while high.
- `measure_valid`  output  1  one-cycle pulse; the measurement outputs were updated this cycle.
- `measure_count`  output  32  rising edges counted in the last completed window.
- `clock_ok`  output  1  last count within ±`tolerance` of `expected_count`.
- `clock_lost`  output  1  last count was zero.

## Operation
- Reset: `reset_n` asserts asynchronously. Release passes through a 2-flop synchronizer before reaching internal logic.
  - Reset values: `measure_valid`=0, `measure_count`=0, `clock_ok`=0, `clock_lost`=0, FSM=IDLE, edge counter=0, sync flops=0.
- Input path: `mon_clk` goes through 2 synchronizer flops and then 1 history flop. `edge` = sync2 & ~hist.
- FSM states:
  - IDLE: wait for `enable`=1, then go to ARM.
  - ARM: 1 cycle. Clear the edge counter and gate timer. Go to GATE.
  - GATE: exactly `gate_cycles` cycles. Each cycle with `edge`=1 increments the counter. After the last gate cycle, go to REPORT.
  - REPORT: 1 cycle. Register the outputs and pulse `measure_valid`. Go to ARM if `enable`=1, else IDLE.
- `enable` low in ARM or GATE: return to IDLE next cycle. The window is discarded, no `measure_valid` is issued, and the previous outputs hold.
- An `edge` during ARM, REPORT or IDLE is not counted. The window covers GATE cycles only.
- Arithmetic:
  - Edge counter is 32-bit unsigned and saturates at 0xFFFF_FFFF. It never wraps.
  - Gate timer width is $clog2(`gate_cycles`+1).
  - Tolerance test uses 33-bit signed difference: `clock_ok` = (|count − expected_count| ≤ `tolerance`).
  - `clock_lost` = (count == 0). If `expected_count` > `tolerance`, `clock_lost`=1 implies `clock_ok`=0.
- Accuracy requires `mon_clk` frequency < `input_frequency`/2; above that the count is undefined. Expected quantisation error is ±1 count.

## Timing
- A `mon_clk` rising edge is seen as `edge` 2–3 `clk` cycles later (synchronizer plus history).
- With `enable` held high, windows run back to back with period `gate_cycles`+2 cycles:
  - first `measure_valid` at cycle `gate_cycles`+2 after `enable` is sampled high in IDLE;
  - every `gate_cycles`+2 cycles after that.
- `measure_count`, `clock_ok` and `clock_lost` change only in the `measure_valid` cycle. They are stable between pulses.
- Reset mid-window: all outputs are zero immediately (asynchronous). Counting restarts through IDLE/ARM once reset is released and synchronized.

## Structure
- Package `clock_monitor_pkg`:
  - FSM state enum (IDLE, ARM, GATE, REPORT);
  - `COUNT_W` = 32;
  - saturation constant.
- Sub-module `clock_monitor_sync`: 2-flop synchronizer plus history flop plus rising-edge output, asynchronous reset. Reused for any other asynchronous status input.
- Top holds the reset synchronizer, FSM, gate timer, counter and compare/output registers.

## Test plan
- `clk` 100 MHz, `mon_clk` 16 MHz, `gate_cycles`=1000, `expected_count`=160, `tolerance`=2 -> every `measure_valid` (1002-cycle period) shows count 159–161, `clock_ok`=1, `clock_lost`=0.
- `mon_clk` held at 0 with the same parameters -> count 0, `clock_lost`=1, `clock_ok`=0.
- `mon_clk` 20 MHz -> count 199–201, `clock_ok`=0, `clock_lost`=0.
- `enable` dropped at gate cycle 500, raised again 10 cycles later -> no `measure_valid` for the aborted window, outputs hold their prior values, next pulse comes 1002 cycles after re-entry to ARM.
- `reset_n` pulsed low mid-GATE -> all outputs 0 in the same cycle; the first post-reset `measure_valid` has the correct count.
- Tiny gate (`gate_cycles`=2) with `mon_clk` = `clk`/4 -> valid pulse every 4 cycles, count 0–1, no X or glitch on outputs.
